// File: rtl/comparator_pkg.sv
// comparator_pkg: shared width default and comparison result encoding
package comparator_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {CMP_LT, CMP_EQ, CMP_GT} cmp_e;
endpackage

// File: rtl/comparator_core.sv
// comparator_core: combinational relation, max/min and |a-b| in unsigned or two's-complement mode
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_mode_i,
  output cmp_e             rel_o,
  output logic [WIDTH-1:0] max_o,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH:0]   diff_o
);
  logic signed [WIDTH:0] ae, be;
  logic lt, eq;
  // one extra bit makes both modes a signed compare and keeps the difference overflow-free
  assign ae = {signed_mode_i & a_i[WIDTH-1], a_i};
  assign be = {signed_mode_i & b_i[WIDTH-1], b_i};
  assign lt = ae < be;
  assign eq = a_i == b_i;
  assign rel_o = lt ? CMP_LT : eq ? CMP_EQ : CMP_GT;
  assign max_o = lt ? b_i : a_i;
  assign min_o = lt ? a_i : b_i;
  assign diff_o = $unsigned(lt ? be - ae : ae - be);
endmodule

// File: rtl/comparator_4bit.sv
// comparator_4bit: registered comparator; results load on in_valid and hold otherwise
module comparator_4bit
  import comparator_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             signed_mode,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH:0]   abs_diff,
  output logic             out_valid
);
  cmp_e rel;
  logic [WIDTH-1:0] mx, mn, max_d, min_d, max_q, min_q;
  logic [WIDTH:0] df, diff_d, diff_q;
  logic gt_d, eq_d, lt_d, gt_q, eq_q, lt_q, valid_q;
  comparator_core #(.WIDTH(WIDTH)) u_core (
    .a_i(a), .b_i(b), .signed_mode_i(signed_mode),
    .rel_o(rel), .max_o(mx), .min_o(mn), .diff_o(df)
  );
  always_comb begin
    gt_d   = in_valid ? rel == CMP_GT : gt_q;
    eq_d   = in_valid ? rel == CMP_EQ : eq_q;
    lt_d   = in_valid ? rel == CMP_LT : lt_q;
    max_d  = in_valid ? mx : max_q;
    min_d  = in_valid ? mn : min_q;
    diff_d = in_valid ? df : diff_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {gt_q, eq_q, lt_q, valid_q} <= '0;
      max_q  <= '0;
      min_q  <= '0;
      diff_q <= '0;
    end else begin
      {gt_q, eq_q, lt_q, valid_q} <= {gt_d, eq_d, lt_d, in_valid};
      max_q  <= max_d;
      min_q  <= min_d;
      diff_q <= diff_d;
    end
  end
  assign {a_gt_b, a_eq_b, a_lt_b, out_valid} = {gt_q, eq_q, lt_q, valid_q};
  assign max_val  = max_q;
  assign min_val  = min_q;
  assign abs_diff = diff_q;
endmodule

// File: tb/tb_comparator_4bit.sv
// tb_comparator_4bit: directed vectors, expected results queued and checked by a monitor
module tb_comparator_4bit;
  typedef struct packed {
    logic gt, eq, lt;
    logic [3:0] mx, mn;
    logic [4:0] df;
  } res_t;
  logic clk = 0, rst = 1, in_valid = 0, signed_mode = 0;
  logic [3:0] a = 0, b = 0;
  logic a_gt_b, a_eq_b, a_lt_b, out_valid;
  logic [3:0] max_val, min_val;
  logic [4:0] abs_diff;
  res_t q[$];
  res_t last = '0, got, exp_r;
  int vectors = 0, miscompares = 0;
  comparator_4bit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .signed_mode(signed_mode),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .max_val(max_val),
    .min_val(min_val), .abs_diff(abs_diff), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  assign got = {a_gt_b, a_eq_b, a_lt_b, max_val, min_val, abs_diff};
  always @(posedge clk) begin
    #1;
    if (rst) last = '0;
    else if (out_valid) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_out_valid: got %h, required no result", got);
      end else begin
        exp_r = q.pop_front();
        if (got !== exp_r) begin
          miscompares++;
          $display("FAIL result: got gt%b eq%b lt%b max%0d min%0d diff%0d, required gt%b eq%b lt%b max%0d min%0d diff%0d",
                   got.gt, got.eq, got.lt, got.mx, got.mn, got.df,
                   exp_r.gt, exp_r.eq, exp_r.lt, exp_r.mx, exp_r.mn, exp_r.df);
        end
        last = exp_r;
      end
    end else begin
      vectors++;
      if (got !== last) begin
        miscompares++;
        $display("FAIL hold: got %h, required %h", got, last);
      end
    end
  end
  task automatic send(input logic sm, input logic [3:0] va, input logic [3:0] vb,
                      input logic [2:0] rel, input logic [3:0] mx, input logic [3:0] mn,
                      input logic [4:0] df);
    @(negedge clk);
    signed_mode = sm; a = va; b = vb; in_valid = 1;
    q.push_back({rel, mx, mn, df});
  endtask
  task automatic check_zero(input string name);
    vectors++;
    if ({got, out_valid} !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h ov%b, required all zero", name, got, out_valid);
    end
  endtask
  initial begin
    a = 1; b = 2; in_valid = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) check_zero("rst_init");
    rst = 0; in_valid = 0;
    send(0, 1, 2, 3'b001, 2, 1, 1);
    send(0, 10, 10, 3'b010, 10, 10, 0);
    send(0, 0, 0, 3'b010, 0, 0, 0);
    send(0, 14, 10, 3'b100, 14, 10, 4);
    send(0, 15, 1, 3'b100, 15, 1, 14);
    send(0, 7, 8, 3'b001, 8, 7, 1);
    send(1, 7, 8, 3'b100, 7, 8, 15);
    send(1, 8, 7, 3'b001, 7, 8, 15);
    send(1, 15, 1, 3'b001, 1, 15, 2);
    send(1, 12, 12, 3'b010, 12, 12, 0);
    send(1, 3, 2, 3'b100, 3, 2, 1);
    send(0, 0, 15, 3'b001, 15, 0, 15);
    @(negedge clk);
    in_valid = 0; a = 5; b = 9; signed_mode = 1;
    repeat (2) @(negedge clk);
    send(0, 3, 5, 3'b001, 5, 3, 2);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1 check_zero("rst_mid");
    in_valid = 1; a = 9; b = 9;
    @(posedge clk);
    #1 check_zero("rst_hold_req");
    @(negedge clk);
    rst = 0; in_valid = 0;
    @(posedge clk);
    #2 check_zero("post_rst");
    send(1, 8, 8, 3'b010, 8, 8, 0);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
